// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
// Contents: FSM state enum, per-scan result enum, matrix geometry constants.
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } kp_scan_t;

endpackage

// File: rtl/keypad_row_driver.sv
// rtl/keypad_row_driver.sv - row strobe divider for the 4x4 keypad matrix
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   row_out     : active-low one-hot row drive
//   row_idx     : index of the row currently driven
//   sample_en   : high during the last divider cycle of a row; the columns
//                 are sampled and the row advances on the following edge
module keypad_row_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [KP_ROWS-1:0]         row_out,
  output logic [$clog2(KP_ROWS)-1:0] row_idx,
  output logic                       sample_en
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(KP_ROWS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign sample_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      row_idx <= '0;
    end else if (sample_en) begin
      div_cnt <= '0;
      row_idx <= row_idx + ROW_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Decoded from the registered index so the drive changes on the same edge.
  assign row_out = ~(KP_ROWS'(1) << row_idx);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with press/release debounce
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   col_in      : active-low column inputs (asynchronous, pulled up)
//   row_out     : active-low one-hot row drive
//   key_code    : accepted key, row*4+col; kept after release
//   key_strobe  : one-cycle pulse on an accepted press
//   key_down    : level from the strobe cycle up to (not incl.) release
//   key_release : one-cycle pulse on an accepted release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KP_COLS-1:0]   col_in,
  output logic [KP_ROWS-1:0]   row_out,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_strobe,
  output logic                 key_down,
  output logic                 key_release
);

  localparam int ROW_W = $clog2(KP_ROWS);
  localparam int COL_W = $clog2(KP_COLS);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_SCANS - 1);

  logic [ROW_W-1:0] row_idx;
  logic             sample_en;

  keypad_row_driver #(.SCAN_DIV(SCAN_DIV)) u_row_driver (
    .clk       (clk),
    .reset     (reset),
    .row_out   (row_out),
    .row_idx   (row_idx),
    .sample_en (sample_en)
  );

  // Two-flop synchronizer on the raw column lines.
  logic [KP_COLS-1:0] col_meta, col_sync;
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Per-row analysis folded into the running scan totals. The hit count
  // saturates at 2 because only 0 / 1 / many matter.
  logic [KP_COLS-1:0]   col_pressed;
  logic [COL_W-1:0]     low_col;
  logic [2:0]           row_hits;
  logic [1:0]           base_cnt, acc_cnt, next_cnt;
  logic [2:0]           sum_cnt;
  logic [KP_CODE_W-1:0] acc_code, next_code;

  always_comb begin
    col_pressed = ~col_sync;
    low_col     = '0;
    row_hits    = '0;
    for (int c = KP_COLS - 1; c >= 0; c--) begin
      if (col_pressed[c]) low_col = COL_W'(c);
    end
    for (int c = 0; c < KP_COLS; c++) begin
      row_hits = row_hits + 3'(col_pressed[c]);
    end
    // Row 0 starts a fresh scan.
    base_cnt  = (row_idx == '0) ? 2'd0 : acc_cnt;
    sum_cnt   = 3'(base_cnt) + row_hits;
    next_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    next_code = (base_cnt == 2'd0) ? {row_idx, low_col} : acc_code;
  end

  logic                 scan_rdy;
  kp_scan_t             scan_res;
  logic [KP_CODE_W-1:0] scan_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt   <= '0;
      acc_code  <= '0;
      scan_rdy  <= 1'b0;
      scan_res  <= NONE;
      scan_code <= '0;
    end else begin
      scan_rdy <= 1'b0;
      if (sample_en) begin
        acc_cnt  <= next_cnt;
        acc_code <= next_code;
        if (row_idx == ROW_W'(KP_ROWS - 1)) begin
          scan_rdy  <= 1'b1;
          scan_code <= next_code;
          case (next_cnt)
            2'd0:    scan_res <= NONE;
            2'd1:    scan_res <= ONE;
            default: scan_res <= MULTI;
          endcase
        end
      end
    end
  end

  kp_state_t            state;
  logic [KP_CODE_W-1:0] cand;
  logic [DB_W-1:0]      db_cnt;
  logic                 is_one, is_cand, is_held;

  assign is_one  = (scan_res == ONE);
  assign is_cand = is_one && (scan_code == cand);
  assign is_held = is_one && (scan_code == key_code);

  // The FSM acts one cycle after scan completion, so the strobe lands on the
  // edge right after the scan that satisfies the debounce count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      db_cnt      <= '0;
      key_code    <= '0;
      key_strobe  <= 1'b0;
      key_down    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      key_release <= 1'b0;
      if (scan_rdy) begin
        case (state)
          IDLE: begin
            if (is_one) begin
              cand <= scan_code;
              if (DEBOUNCE_SCANS == 1) begin
                state      <= HELD;
                key_code   <= scan_code;
                key_strobe <= 1'b1;
                key_down   <= 1'b1;
              end else begin
                state  <= PRESS_DB;
                db_cnt <= DB_ONE;
              end
            end
          end
          PRESS_DB: begin
            if (is_cand) begin
              if (db_cnt >= DB_LAST) begin
                state      <= HELD;
                key_code   <= cand;
                key_strobe <= 1'b1;
                key_down   <= 1'b1;
                db_cnt     <= '0;
              end else begin
                db_cnt <= db_cnt + DB_ONE;
              end
            end else if (is_one) begin
              cand   <= scan_code;
              db_cnt <= DB_ONE;
            end else begin
              state  <= IDLE;
              db_cnt <= '0;
            end
          end
          HELD: begin
            // Extra keys alongside the held one are ignored.
            if (!(is_held || scan_res == MULTI)) begin
              if (DEBOUNCE_SCANS == 1) begin
                state       <= IDLE;
                key_release <= 1'b1;
                key_down    <= 1'b0;
              end else begin
                state  <= RELEASE_DB;
                db_cnt <= DB_ONE;
              end
            end
          end
          RELEASE_DB: begin
            if (is_held) begin
              state  <= HELD;
              db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
              state       <= IDLE;
              key_release <= 1'b1;
              key_down    <= 1'b0;
              db_cnt      <= '0;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_strobe;
  logic       key_down;
  logic       key_release;

  logic [15:0] keys;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int release_cnt = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .col_in      (col_in),
    .row_out     (row_out),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .key_down    (key_down),
    .key_release (key_release)
  );

  // Matrix model: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_strobe) strobe_cnt++;
    if (key_release) release_cnt++;
    if (key_strobe && key_release) both_seen++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and row stepping
    chk("rst_row", 8'(row_out), 8'h0E);
    chk("rst_code", 8'(key_code), 8'h0);
    chk("rst_strobe", 8'(key_strobe), 8'h0);
    chk("rst_down", 8'(key_down), 8'h0);
    chk("rst_release", 8'(key_release), 8'h0);
    adv(4);  chk("row1", 8'(row_out), 8'h0D);
    adv(4);  chk("row2", 8'(row_out), 8'h0B);
    adv(4);  chk("row3", 8'(row_out), 8'h07);
    adv(4);  chk("row0_wrap", 8'(row_out), 8'h0E);

    // Clean press of key 9 (row 2, col 1)
    adv(1);  keys = 16'(1 << 9);
    adv(47); chk("press_pre_strobe", 8'(key_strobe), 8'h0);
    adv(1);  chk("press_strobe", 8'(key_strobe), 8'h1);
             chk("press_code", 8'(key_code), 8'h9);
             chk("press_down", 8'(key_down), 8'h1);
    adv(1);  chk("press_strobe_end", 8'(key_strobe), 8'h0);
             chk("press_down_hold", 8'(key_down), 8'h1);
    adv(47); chk("press_one_strobe", 8'(strobe_cnt), 8'd1);
             chk("press_still_down", 8'(key_down), 8'h1);

    // Release glitch: one NONE scan, then key back
    keys = '0;
    adv(16); chk("glitch_down", 8'(key_down), 8'h1);
    keys = 16'(1 << 9);
    adv(32); chk("glitch_no_release", 8'(release_cnt), 8'd0);
             chk("glitch_no_strobe", 8'(strobe_cnt), 8'd1);
             chk("glitch_down_after", 8'(key_down), 8'h1);

    // Permanent release
    keys = '0;
    adv(47); chk("rel_pre", 8'(key_release), 8'h0);
             chk("rel_pre_down", 8'(key_down), 8'h1);
    adv(1);  chk("rel_pulse", 8'(key_release), 8'h1);
             chk("rel_down", 8'(key_down), 8'h0);
             chk("rel_code", 8'(key_code), 8'h9);
    adv(1);  chk("rel_pulse_end", 8'(key_release), 8'h0);
             chk("rel_count", 8'(release_cnt), 8'd1);

    // Bounce: alternate scans, then stable
    adv(15); keys = 16'(1 << 9);
    adv(16); keys = '0;
    adv(16); keys = 16'(1 << 9);
    adv(16); keys = '0;
    adv(16); keys = 16'(1 << 9);
    adv(47); chk("bounce_no_strobe", 8'(strobe_cnt), 8'd1);
             chk("bounce_pre", 8'(key_strobe), 8'h0);
    adv(1);  chk("bounce_strobe", 8'(key_strobe), 8'h1);
             chk("bounce_code", 8'(key_code), 8'h9);

    // Reset mid-hold
    adv(8);  reset = 1'b1;
    adv(1);  chk("mrst_row", 8'(row_out), 8'h0E);
             chk("mrst_code", 8'(key_code), 8'h0);
             chk("mrst_down", 8'(key_down), 8'h0);
             chk("mrst_strobe", 8'(key_strobe), 8'h0);
             chk("mrst_release", 8'(key_release), 8'h0);
             reset = 1'b0;
    adv(48); chk("mrst_pre", 8'(key_strobe), 8'h0);
             chk("mrst_no_release", 8'(release_cnt), 8'd1);
             chk("mrst_strobe_cnt", 8'(strobe_cnt), 8'd2);
    adv(1);  chk("mrst_reaccept", 8'(key_strobe), 8'h1);
             chk("mrst_reaccept_code", 8'(key_code), 8'h9);
             chk("mrst_reaccept_down", 8'(key_down), 8'h1);

    // Release, then two keys from IDLE
    keys = '0;
    adv(48); chk("rel2_pulse", 8'(key_release), 8'h1);
             chk("rel2_down", 8'(key_down), 8'h0);
    keys = 16'h0021;
    adv(80); chk("multi_no_strobe", 8'(strobe_cnt), 8'd3);
             chk("multi_down", 8'(key_down), 8'h0);

    // Key 5 alone accepted, then key 0 added while held
    keys = 16'h0020;
    adv(48); chk("k5_strobe", 8'(key_strobe), 8'h1);
             chk("k5_code", 8'(key_code), 8'h5);
    adv(16); keys = 16'h0021;
    adv(64); chk("k5_multi_down", 8'(key_down), 8'h1);
             chk("k5_multi_strobes", 8'(strobe_cnt), 8'd4);
             chk("k5_multi_releases", 8'(release_cnt), 8'd2);
    keys = '0;
    adv(48); chk("k5_release", 8'(key_release), 8'h1);
             chk("k5_release_code", 8'(key_code), 8'h5);
             chk("k5_release_down", 8'(key_down), 8'h0);
    adv(1);  chk("final_releases", 8'(release_cnt), 8'd3);
             chk("never_both", 8'(both_seen), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 active-low matrix keypad and debounces presses into the single-key code and strobe interface that the game module consumes on keypad_reg/keypad_enable.
- Sits between the board keypad pins and the game module.
- Emits exactly one strobe per accepted press, a level while the key is held, and one release pulse.

Parameters:
- SCAN_DIV, 50000: clocks each row is driven before its columns are sampled; must be >= 4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-matrix scans required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- col_in  input  4  keypad column lines, active-low, externally pulled up, asynchronous.
- row_out  output  4  keypad row drive, active-low one-hot.
- key_code  output  4  code of the accepted key, row*4+col; holds its value after release.
- key_strobe  output  1  one-cycle pulse on an accepted press; connects to keypad_enable.
- key_down  output  1  high from the strobe cycle until the release pulse cycle, inclusive of the strobe and exclusive of the release.
- key_release  output  1  one-cycle pulse on an accepted release.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: row_out=4'b1110 (row 0 active), key_code=0, key_strobe=0, key_down=0, key_release=0. Divider, row index, debounce counter and FSM are all cleared. Reset asserted mid-scan or mid-hold takes effect on the next clk edge, and no release pulse is emitted.
- Synchronizer: col_in passes through a 2-FF synchronizer; all logic uses the synchronized value.
- Divider: counts 0..SCAN_DIV-1. On terminal count, the synchronized columns are sampled for the current row, then the row index advances 0->1->2->3->0. row_out changes on the same edge.
- Scan accumulation: within one scan (rows 0..3), record the first pressed key (lowest row, then lowest column) and count the pressed keys.
- Scan result: produced at the row-3 sample and classified as NONE (0 keys), ONE(code) (exactly 1 key), or MULTI (2 or more keys).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. The debounce counter db_cnt is updated only at scan completion.
  - IDLE: ONE(c) -> PRESS_DB with cand=c, db_cnt=1. NONE or MULTI -> stay.
  - PRESS_DB:
    - ONE(cand) -> db_cnt+1. When db_cnt reaches DEBOUNCE_SCANS, go to HELD.
    - ONE(other) -> cand=other, db_cnt=1.
    - NONE or MULTI -> IDLE.
  - With DEBOUNCE_SCANS=1, IDLE goes straight to HELD on the first ONE.
  - HELD entry: key_code<=cand and key_strobe=1 for exactly one cycle, key_down<=1.
  - HELD: ONE(key_code) or MULTI -> stay. NONE or ONE(other) -> RELEASE_DB with db_cnt=1.
  - RELEASE_DB:
    - Not ONE(key_code) -> db_cnt+1. At DEBOUNCE_SCANS, key_release=1 for one cycle, key_down<=0, go to IDLE.
    - ONE(key_code) -> back to HELD with no new strobe.
  - A different key is only ever accepted after the release of the held key has completed.
- Latency: the strobe asserts on the clk edge immediately after the scan-completion edge that meets the debounce condition. A stable press is therefore accepted within (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles.
- key_strobe and key_release are never high in the same cycle.
- Counter widths: $clog2(SCAN_DIV) for the divider, $clog2(DEBOUNCE_SCANS+1) for db_cnt; db_cnt saturates at DEBOUNCE_SCANS.

Decomposition:
- Shared package keypad_pkg contains:
  - state enum {IDLE, PRESS_DB, HELD, RELEASE_DB};
  - scan result enum {NONE, ONE, MULTI};
  - constants KP_ROWS=4, KP_COLS=4, KP_CODE_W=4.
- One sub-module, keypad_row_driver: the divider, the row index, row_out and the sample-enable pulse.
- The synchronizer, scan accumulation and FSM stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan = 16 cycles):
- Reset: hold reset 3 cycles, then release. row_out=1110 and all outputs 0. row_out then steps 1101 after 4 cycles, 1011 after 8, 0111 after 12, back to 1110 after 16.
- Clean press: model key row 2 / col 1 pulling col_in[1] low when row_out[2]=0, hold 6 scans. Expect one key_strobe with key_code=9, in the cycle after the 3rd completed scan; key_down stays 1 while held.
- Bounce: toggle that key on alternate scans for 4 scans, then hold steadily. Expect no strobe during bouncing and exactly one strobe after 3 stable scans.
- Release glitch: with key 9 held, drop it for 1 scan, then restore it. Expect no key_release and no second strobe. Then release permanently: key_release after 3 NONE scans, key_down=0, key_code stays 9.
- Multi-key: press keys 0 and 5 together from IDLE. Expect no strobe. While key 5 is HELD, add key 0: expect key_down stays 1 and no events.
- Reset mid-hold: while HELD, assert reset for 1 cycle. Expect all outputs 0 with no key_release, then re-acceptance of the still-pressed key after 3 scans.
